// File: rtl/fp_result_arbiter_pkg.sv
// Shared types for the FP result arbiter: FSM state encoding and default width.
// Arbitration mode is chosen by the RR_ARB_EN macro in the control unit.
package fp_result_arbiter_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp_arb_pick.sv
// Combinational picker: first valid slot found when searching upward from ptr_i,
// wrapping modulo NREQ. A zero pointer gives lowest-index-first priority.
module fp_arb_pick
    import fp_result_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] vld_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   gnt_o,
    output logic            any_o
);

    int idx;

    // Walk the slots from the pointer, wrapping, and keep the first valid one.
    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_o && vld_i[idx[IW-1:0]]) begin
                any_o = 1'b1;
                gnt_o = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_result_arbiter_cu.sv
// Control unit: IDLE/PRESENT/RELEASE four-phase handshake FSM and grant pointer.
// RR_ARB_EN defined: rotating search pointer; undefined: pointer fixed at 0.
module fp_result_arbiter_cu
    import fp_result_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          any_i,
    input  logic [IW-1:0] pick_i,
    input  logic          acc_i,
    output logic [IW-1:0] ptr_o,
    output logic          load_o,
    output logic          clr_o,
    output logic [IW-1:0] gid_o,
    output logic          ready_o
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] gid_q, gid_d;

    // State and grant id registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
        end
    end

    // Handshake sequencing: grant in IDLE, present until ack, wait for ack release.
    always_comb begin
        state_d = state_q;
        gid_d   = gid_q;
        load_o  = 1'b0;
        clr_o   = 1'b0;
        ready_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_i) begin
                    load_o  = 1'b1;
                    gid_d   = pick_i;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                ready_o = 1'b1;
                if (acc_i) begin
                    clr_o   = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!acc_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gid_o = gid_q;

`ifdef RR_ARB_EN
    logic [IW-1:0] ptr_q, ptr_d;

    // Next search starts just past the source granted most recently.
    always_comb begin
        ptr_d = ptr_q;
        if (load_o) begin
            if (pick_i == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_i + 1'b1;
            end
        end
    end

    // Round-robin pointer register; source 0 searched first after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
`else
    assign ptr_o = '0;
`endif

endmodule

// File: rtl/fp_result_arbiter_dp.sv
// Datapath: done edge detect, per-source capture slots, overflow flag and
// the registered output word.
module fp_result_arbiter_dp
    import fp_result_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEFAULT_W,
    parameter int IW   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] done_i,
    input  logic [NREQ*W-1:0] result_i,
    input  logic            load_i,
    input  logic [IW-1:0]   sel_i,
    input  logic            clr_i,
    input  logic [IW-1:0]   clr_idx_i,
    output logic [NREQ-1:0] vld_o,
    output logic [W-1:0]    bus_o,
    output logic            ovf_o
);

    logic [NREQ-1:0] done_q;
    logic [NREQ-1:0] rise;
    logic [NREQ-1:0] clr_vec;
    logic [NREQ-1:0] vld_q, vld_d;
    logic [W-1:0]    slot_q [NREQ];
    logic [W-1:0]    slot_d [NREQ];
    logic [W-1:0]    bus_q, bus_d;
    logic            ovf_q, ovf_d;

    assign rise    = done_i & ~done_q;
    assign clr_vec = clr_i ? (NREQ'(1) << clr_idx_i) : '0;

    // Slot capture on done rise; a rise into a full, uncleared slot is dropped.
    always_comb begin
        vld_d  = vld_q;
        slot_d = slot_q;
        ovf_d  = ovf_q;
        bus_d  = bus_q;
        for (int i = 0; i < NREQ; i++) begin
            if (rise[i]) begin
                if (vld_q[i] && !clr_vec[i]) begin
                    ovf_d = 1'b1;
                end else begin
                    slot_d[i] = result_i[i*W +: W];
                    vld_d[i]  = 1'b1;
                end
            end else if (clr_vec[i]) begin
                vld_d[i] = 1'b0;
            end
        end
        if (load_i) begin
            bus_d = slot_q[sel_i];
        end
    end

    // Edge-detect history, slots, output word and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= '0;
            vld_q  <= '0;
            bus_q  <= '0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            done_q <= done_i;
            vld_q  <= vld_d;
            bus_q  <= bus_d;
            ovf_q  <= ovf_d;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign vld_o = vld_q;
    assign bus_o = bus_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/fp_result_arbiter.sv
// FP result arbiter top: merges NREQ completion sources onto one four-phase
// consumer port. Define RR_ARB_EN for round-robin, else fixed priority.
module fp_result_arbiter
    import fp_result_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = DEFAULT_W,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   done,
    input  logic [NREQ*W-1:0] result,
    output logic [NREQ-1:0]   busy,
    output logic [W-1:0]      out_bus,
    output logic [IW-1:0]     grant_id,
    output logic              result_ready,
    input  logic              result_accepted,
    output logic              ovf
);

    logic [NREQ-1:0] vld;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;
    logic            any;
    logic            load;
    logic            clr;

    fp_arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .vld_i (vld),
        .ptr_i (ptr),
        .gnt_o (pick),
        .any_o (any)
    );

    fp_result_arbiter_cu #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_cu (
        .clk_i   (clk),
        .rst_i   (rst),
        .any_i   (any),
        .pick_i  (pick),
        .acc_i   (result_accepted),
        .ptr_o   (ptr),
        .load_o  (load),
        .clr_o   (clr),
        .gid_o   (grant_id),
        .ready_o (result_ready)
    );

    fp_result_arbiter_dp #(
        .NREQ (NREQ),
        .W    (W),
        .IW   (IW)
    ) u_dp (
        .clk_i     (clk),
        .rst_i     (rst),
        .done_i    (done),
        .result_i  (result),
        .load_i    (load),
        .sel_i     (pick),
        .clr_i     (clr),
        .clr_idx_i (grant_id),
        .vld_o     (vld),
        .bus_o     (out_bus),
        .ovf_o     (ovf)
    );

    assign busy = vld;

endmodule

// File: tb/tb_fp_result_arbiter.sv
// Directed scoreboard bench for fp_result_arbiter (NREQ=4, W=32).
// Expected grant order follows RR_ARB_EN when it is defined.
module tb_fp_result_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   done = '0;
    logic [NREQ*W-1:0] result = '0;
    logic [NREQ-1:0]   busy;
    logic [W-1:0]      out_bus;
    logic [1:0]        grant_id;
    logic              result_ready;
    logic              result_accepted = 1'b0;
    logic              ovf;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   seen;

    always #5 clk = ~clk;

    fp_result_arbiter #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .done            (done),
        .result          (result),
        .busy            (busy),
        .out_bus         (out_bus),
        .grant_id        (grant_id),
        .result_ready    (result_ready),
        .result_accepted (result_accepted),
        .ovf             (ovf)
    );

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        done = '0;
        result_accepted = 1'b0;
        step(2);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drive(int i, logic [W-1:0] v);
        result[i*W +: W] = v;
        done[i] = 1'b1;
    endtask

    task automatic expect_res(int i, logic [W-1:0] v);
        exp_t x;
        x.id = 2'(i);
        x.data = v;
        sb.push_back(x);
    endtask

    // Wait for a presented result, score it, then run the four-phase ack.
    task automatic consume(string tag, int hold);
        exp_t x;
        int n = 0;
        while (!result_ready && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_wait"}, 32'(n < 40), 32'd1);
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({tag, "_bus"}, out_bus, x.data);
            chk({tag, "_gid"}, 32'(grant_id), 32'(x.id));
        end
        result_accepted = 1'b1;
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, "_rel"}, 32'(result_ready), 32'd0);
        end
        result_accepted = 1'b0;
        step();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", 32'(result_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_bus", out_bus, 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);

        // Held done: single capture, two-edge latency
        drive(2, 32'h4000_0000);
        expect_res(2, 32'h4000_0000);
        step();
        chk("lat_e1_ready", 32'(result_ready), 32'd0);
        chk("lat_e1_busy", 32'(busy), 32'h4);
        step();
        chk("lat_e2_ready", 32'(result_ready), 32'd1);
        step();
        done = '0;
        chk("hold_busy", 32'(busy), 32'h4);
        chk("hold_ovf", 32'(ovf), 32'd0);
        consume("held", 1);
        chk("held_busy_after", 32'(busy), 32'd0);

        // Simultaneous sources 0 and 3, pointer at 0
        do_reset();
        drive(0, 32'hA000_0000);
        drive(3, 32'hA000_0003);
        expect_res(0, 32'hA000_0000);
        expect_res(3, 32'hA000_0003);
        step();
        done = '0;
        consume("pair0_a", 1);
        consume("pair0_b", 1);

        // Pointer moved to 1 by a lone grant of source 0
        do_reset();
        drive(0, 32'hB000_0000);
        expect_res(0, 32'hB000_0000);
        step();
        done = '0;
        consume("solo0", 1);
        drive(0, 32'hC000_0000);
        drive(3, 32'hC000_0003);
`ifdef RR_ARB_EN
        expect_res(3, 32'hC000_0003);
        expect_res(0, 32'hC000_0000);
`else
        expect_res(0, 32'hC000_0000);
        expect_res(3, 32'hC000_0003);
`endif
        step();
        done = '0;
        consume("pair1_a", 1);
        consume("pair1_b", 1);

        // Overflow on a full, ungranted slot; long ack hold
        do_reset();
        drive(0, 32'h1111_0000);
        drive(1, 32'h1111_0001);
        expect_res(0, 32'h1111_0000);
        expect_res(1, 32'h1111_0001);
        step();
        done = '0;
        step();
        drive(1, 32'h2222_0001);
        step();
        done = '0;
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_busy", 32'(busy), 32'h3);
        consume("ovf_a", 5);
        consume("ovf_b", 1);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        chk("ovf_busy_end", 32'(busy), 32'd0);

        // Ack coincides with a new rise on the granted source
        do_reset();
        drive(1, 32'h1234_5678);
        step();
        done = '0;
        step();
        chk("coin_ready", 32'(result_ready), 32'd1);
        chk("coin_bus0", out_bus, 32'h1234_5678);
        chk("coin_gid0", 32'(grant_id), 32'd1);
        expect_res(1, 32'h3F80_0000);
        drive(1, 32'h3F80_0000);
        result_accepted = 1'b1;
        step();
        chk("coin_busy", 32'(busy), 32'h2);
        chk("coin_ovf", 32'(ovf), 32'd0);
        result_accepted = 1'b0;
        done = '0;
        step();
        consume("coin", 1);
        chk("coin_ovf_end", 32'(ovf), 32'd0);

        // Reset in PRESENT with three slots full
        do_reset();
        drive(0, 32'h5000_0000);
        drive(1, 32'h5000_0001);
        drive(2, 32'h5000_0002);
        step();
        done = '0;
        step();
        chk("mid_ready", 32'(result_ready), 32'd1);
        chk("mid_busy", 32'(busy), 32'h7);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(result_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        sb.delete();
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (result_ready) seen++;
        end
        chk("mid_no_deliver", 32'(seen), 32'd0);
        chk("mid_busy_end", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
